decode_pipe: RTL

- Registered MIPS instruction-decode stage with an ID/EX pipeline register.
- Decodes R/I/J-format instructions into the jump, ALU, register-ID and write-enable fields that EX consumes.
- Adds what the combinational decoder lacks: valid/ready handshake, load-use hazard interlock with bubble insertion, flush on redirect, and a back-pressure hold.
- Sits between the IF/ID register and the register-file read / EX stage.

---
 rtl/decode_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - MIPS decode stage with ID/EX register, load-use interlock, flush and hold.
// Optional macro DECODE_BNE_EN enables opcode 05 (BNE); otherwise it decodes as illegal.
module decode_pipe #(
  parameter int DWIDTH  = 32,
  parameter int RID_W   = 5,
  parameter int JADDR_W = DWIDTH - 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DWIDTH-1:0]  instr,
  input  logic [DWIDTH-1:0]  in_pc,
  input  logic               flush,
  input  logic               ex_stall,
  output logic               ex_valid,
  output logic [DWIDTH-1:0]  ex_pc,
  output logic [2:0]         jump_type,
  output logic [JADDR_W-1:0] jump_addr,
  output logic [3:0]         op,
  output logic               ssel,
  output logic [DWIDTH-1:0]  imm,
  output logic [RID_W-1:0]   rs1_id,
  output logic [RID_W-1:0]   rs2_id,
  output logic [RID_W-1:0]   rdst_id,
  output logic               we_regfile,
  output logic               we_dmem,
  output logic               re_dmem,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_NOR = 4'd4, OP_SLT = 4'd5, OP_NOT_DEFINED = 4'd15;
  localparam logic [2:0] JT_NOP = 3'd0, JT_J = 3'd1, JT_JAL = 3'd2, JT_JR = 3'd3,
                         JT_BEQ = 3'd4, JT_BNE = 3'd5;

  logic [5:0]       opc, funct;
  logic [RID_W-1:0] rs, rt, rd;
  assign opc   = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = RID_W'(instr[25:21]);
  assign rt    = RID_W'(instr[20:16]);
  assign rd    = RID_W'(instr[15:11]);

  if (DWIDTH > 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^instr[DWIDTH-1:32];
  end

  logic [2:0]        d_jt;
  logic [3:0]        d_op;
  logic              d_ssel, d_we, d_wm, d_rm, d_ill, rt_src;
  logic [DWIDTH-1:0] d_imm;
  logic [RID_W-1:0]  d_rdst;

  always_comb begin
    d_jt   = JT_NOP;
    d_op   = OP_NOT_DEFINED;
    d_ssel = 1'b0;
    d_imm  = DWIDTH'($signed(instr[15:0]));
    d_rdst = rd;
    d_we   = 1'b1;
    d_wm   = 1'b0;
    d_rm   = 1'b0;
    d_ill  = 1'b0;
    rt_src = 1'b0;
    case (opc)
      6'h00: begin
        d_ssel = 1'b1;
        d_imm  = '0;
        rt_src = 1'b1;
        case (funct)
          6'h20: d_op = OP_ADD;
          6'h22: d_op = OP_SUB;
          6'h24: d_op = OP_AND;
          6'h25: d_op = OP_OR;
          6'h27: d_op = OP_NOR;
          6'h2A: d_op = OP_SLT;
          6'h08: begin d_jt = JT_JR; d_rdst = '0; end
          default: d_ill = 1'b1;
        endcase
      end
      6'h02: begin d_jt = JT_J; d_we = 1'b0; end
      6'h03: begin d_jt = JT_JAL; d_rdst = '1; d_imm = '0; end
      6'h04: begin d_jt = JT_BEQ; d_op = OP_OR; d_we = 1'b0; d_ssel = 1'b1; rt_src = 1'b1; end
`ifdef DECODE_BNE_EN
      6'h05: begin d_jt = JT_BNE; d_op = OP_OR; d_we = 1'b0; d_ssel = 1'b1; rt_src = 1'b1; end
`endif
      6'h08: begin d_op = OP_ADD; d_rdst = rt; end
      6'h0A: begin d_op = OP_SLT; d_rdst = rt; end
      6'h23: begin d_op = OP_ADD; d_rdst = rt; d_rm = 1'b1; end
      6'h2B: begin d_op = OP_ADD; d_we = 1'b0; d_wm = 1'b1; rt_src = 1'b1; end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op = OP_NOT_DEFINED;
      d_jt = JT_NOP;
      d_we = 1'b0;
      d_wm = 1'b0;
      d_rm = 1'b0;
    end
  end

  // A load in ID/EX whose target is read by the instruction now in ID must wait one cycle.
  logic hazard;
  assign hazard = ex_valid && re_dmem && (rdst_id != '0) && in_valid &&
                  ((rdst_id == rs) || (rt_src && (rdst_id == rt)));

  assign in_ready = rst_n && (flush || (!ex_stall && !hazard));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      jump_type  <= JT_NOP;
      jump_addr  <= '0;
      op         <= '0;
      ssel       <= 1'b0;
      imm        <= '0;
      rs1_id     <= '0;
      rs2_id     <= '0;
      rdst_id    <= '0;
      we_regfile <= 1'b0;
      we_dmem    <= 1'b0;
      re_dmem    <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush || (!ex_stall && !(in_valid && !hazard))) begin
      // Bubble: only the fields that can cause side effects are cleared.
      ex_valid   <= 1'b0;
      jump_type  <= JT_NOP;
      we_regfile <= 1'b0;
      we_dmem    <= 1'b0;
      re_dmem    <= 1'b0;
      illegal    <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid   <= 1'b1;
      ex_pc      <= in_pc;
      jump_type  <= d_jt;
      jump_addr  <= JADDR_W'(instr[25:0]);
      op         <= d_op;
      ssel       <= d_ssel;
      imm        <= d_imm;
      rs1_id     <= rs;
      rs2_id     <= rt;
      rdst_id    <= d_rdst;
      we_regfile <= d_we;
      we_dmem    <= d_wm;
      re_dmem    <= d_rm;
      illegal    <= d_ill;
    end
  end

endmodule
